i2c_master_core: RTL and testbench
==================================

# i2c_master_core

Single-byte I2C master that generates SCL, START, address, data, ACK and STOP on the board clock. It sits directly upstream of the I2C slave in the multi-protocol module. It drives the slave's `sclk` and `sda` inputs and consumes the slave's `slave_sda_en`/`ssda_buffer` through the top-level SDA resolve. A user command (7-bit address, read/write, write byte) is converted into one complete bus transaction, with a `done` pulse and an `ack_err` result.

## Interface
- `BOARD_FREQ`, default 125000000: system clock in Hz.
- `I2C_FREQ`, default 312500: bus bit rate in Hz.
- `BIT_DUR`, default BOARD_FREQ/I2C_FREQ (400): clk cycles per bit.
- `DELTA`, default BIT_DUR/4 (100): cycles per quarter-bit phase.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `newd`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  transfer direction: 1 = read, 0 = write; captured with `newd`.
- `addr`  in  7  slave address; captured with `newd`.
- `din`  in  8  byte to write; captured with `newd`.
- `sda_in`  in  1  resolved SDA line.
- `sclk`  out  1  bus clock.
- `master_sda_en`  out  1  high while the master drives SDA.
- `msda_buffer`  out  1  SDA value driven when `master_sda_en`=1.
- `dout`  out  8  byte read from the slave; valid from `done` until the next accepted command.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `ack_err`  out  1  high if any slave ACK slot was sampled as 1; held until the next accepted command.
- `done`  out  1  single-cycle pulse at the end of STOP.

## Operation
- Reset and idle output values: `sclk`=1, `master_sda_en`=1, `msda_buffer`=1, `dout`=0, `busy`=0, `ack_err`=0, `done`=0. State = IDLE, phase counter = 0.
- Phase counter runs from 0 to BIT_DUR-1 while busy, and is held at 0 in IDLE.
  - Phase p = count/DELTA.
  - Bit boundary: count = BIT_DUR-1.
- Data bits: `sclk`=0 in phases 0–1 and 1 in phases 2–3.
  - Master updates `msda_buffer` at count = DELTA (100).
  - Master samples `sda_in` at count = 2·DELTA (200).
- States:
  - IDLE: on `newd`=1, latch `op`/`addr`/`din`, clear `ack_err`, set `busy`, go to START.
  - START (1 bit): `sclk`=1 throughout; `msda_buffer`=1 in phases 0–1 and 0 in phases 2–3.
  - WRITE_ADDR (8 bits): send {addr, op}, MSB first; en=1.
  - ADDR_ACK (1 bit): en=0; sample `sda_in`. A 1 sets `ack_err` and goes to STOP. A 0 goes to WRITE_DATA if `op`=0, else READ_DATA.
  - WRITE_DATA (8 bits): send `din`, MSB first; en=1.
  - DATA_ACK (1 bit): en=0; a sample of 1 sets `ack_err`; then go to STOP.
  - READ_DATA (8 bits): en=0; shift `sda_in` into `dout`, MSB first.
  - MASTER_NACK (1 bit): en=1, `msda_buffer`=1 (single-byte read ends with NACK); then go to STOP.
  - STOP (1 bit): en=1.
    - Phase 0: `sclk`=0, SDA=0.
    - Phase 1: `sclk`=1, SDA=0.
    - Phases 2–3: `sclk`=1, SDA=1.
    - At the bit boundary, pulse `done`, clear `busy`, return to IDLE.
- Bit counter is 4 bits, counts 0..7 within multi-bit states, and is cleared on each state exit.
- `newd` while `busy`=1 is ignored and never queued.
- `newd` in the same cycle as `done` is ignored; acceptance occurs on the next IDLE cycle.
- Reset asserted mid-transaction aborts immediately to the idle values; no STOP is generated.

## Timing
- Acceptance: `newd` high in IDLE at cycle 0 → `busy`=1 and count=0 at cycle 1.
- Full write or read transaction: 20 bit periods (1+8+1+8+1+1) = 8000 clk; `done` at cycle 8000 after acceptance.
- Address NACK: 11 bit periods = 4400 clk.
- `dout` is final at the last READ_DATA sample and is stable by the time `done` pulses.
- `ack_err` updates at the sample cycle (count 200) of the failing ACK slot.
- SDA changes only while `sclk`=0, except the START and STOP edges, which occur at the phase 1→2 boundary while `sclk`=1.

## Structure
- Shared package `i2c_pkg` holds:
  - State encodings.
  - BOARD_FREQ / I2C_FREQ defaults.
  - DELTA / BIT_DUR.
  - Phase constants PH_DRIVE=100, PH_SAMPLE=200, PH_END=399, for reuse by the slave.
- Sub-module `i2c_phase_gen` provides the counter plus `phase[1:0]`, `drive_tick`, `sample_tick` and `bit_end`, enabled by `busy`. The FSM and shift registers stay in the top.

## Test plan
- Write, then read back through the slave model: write 0xA5 to address 0x03 → `ack_err`=0, `done` at +8000 clk. Then read address 0x03 → `dout`=0xA5, `ack_err`=0.
- Read from a reset slave: read address 0x05 → `dout`=0x05 (memory initial value = index). Master drives SDA=1 in the NACK slot; slave reports no error.
- Address NACK: slave disconnected, `sda_in` held at 1 → `ack_err`=1 at ADDR_ACK. No data phase; `done` at +4400 clk; final `sclk`=1 and SDA=1.
- Protocol checker on SDA/SCL: every SDA transition occurs while `sclk`=0, except exactly one START (SDA 1→0) and one STOP (SDA 0→1) per transaction, both with `sclk`=1.
- `newd` pulsed 1000 clk into a transaction with a different address → ignored: original address on the bus, only one `done`.
- Reset asserted at cycle 3000 of a write → next cycle all outputs are at idle values. A new command after release completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master (and the companion slave):
//   - default board / bus frequencies and the derived bit timing
//   - quarter-bit phase landmarks (drive, sample, end of bit)
//   - master FSM state encoding
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int DEF_BOARD_FREQ = 125000000;
    localparam int DEF_I2C_FREQ   = 312500;
    localparam int DEF_BIT_DUR    = DEF_BOARD_FREQ / DEF_I2C_FREQ;  // 400 clk per bit
    localparam int DEF_DELTA      = DEF_BIT_DUR / 4;                // 100 clk per phase

    // Landmarks inside one bit period (phase counter values)
    localparam int PH_DRIVE  = DEF_DELTA;         // SDA is updated here (SCL low)
    localparam int PH_SAMPLE = 2 * DEF_DELTA;     // SDA is sampled here (SCL rising)
    localparam int PH_END    = DEF_BIT_DUR - 1;   // last cycle of the bit

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_START       = 4'd1,
        ST_WRITE_ADDR  = 4'd2,
        ST_ADDR_ACK    = 4'd3,
        ST_WRITE_DATA  = 4'd4,
        ST_DATA_ACK    = 4'd5,
        ST_READ_DATA   = 4'd6,
        ST_MASTER_NACK = 4'd7,
        ST_STOP        = 4'd8
    } i2c_state_t;

endpackage

// File: rtl/i2c_phase_gen.sv
// -----------------------------------------------------------------------------
// i2c_phase_gen
// Bit-period timer for the I2C master. While en=1 the counter runs
// 0..BIT_DUR-1 and wraps; while en=0 it is held at 0.
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   en            run enable (master busy)
//   phase[1:0]    quarter of the current bit (count / DELTA)
//   drive_tick    count == DELTA     (SDA update point)
//   sample_tick   count == 2*DELTA   (SDA sample point)
//   bit_end       count == BIT_DUR-1 (last cycle of the bit)
// -----------------------------------------------------------------------------
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int BIT_DUR = DEF_BIT_DUR,
    parameter int DELTA   = DEF_DELTA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] phase,
    output logic       drive_tick,
    output logic       sample_tick,
    output logic       bit_end
);

    localparam int CW = $clog2(BIT_DUR);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (!en) begin
            r_count <= '0;
        end else if (r_count == CW'(BIT_DUR - 1)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // Range compares instead of a divide by DELTA
    always_comb begin
        phase = 2'd0;
        if (r_count >= CW'(3 * DELTA)) begin
            phase = 2'd3;
        end else if (r_count >= CW'(2 * DELTA)) begin
            phase = 2'd2;
        end else if (r_count >= CW'(DELTA)) begin
            phase = 2'd1;
        end
    end

    assign drive_tick  = (r_count == CW'(DELTA));
    assign sample_tick = (r_count == CW'(2 * DELTA));
    assign bit_end     = (r_count == CW'(BIT_DUR - 1));

endmodule

// File: rtl/i2c_master_core.sv
// -----------------------------------------------------------------------------
// i2c_master_core
// Single-byte I2C master: one command (7-bit address, direction, write byte)
// becomes START, address+R/W, ACK, one data byte, ACK/NACK and STOP.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   newd            command strobe (op/addr/din captured with it)
//   op              1 = read, 0 = write
//   addr[6:0]       slave address
//   din[7:0]        byte to write
//   sda_in          resolved SDA line
//   sclk            bus clock
//   master_sda_en   1 while the master drives SDA
//   msda_buffer     value driven on SDA when master_sda_en = 1
//   dout[7:0]       byte read from the slave
//   busy            transaction in progress
//   ack_err         some ACK slot was sampled as 1 (held until next command)
//   done            one-cycle pulse on the last cycle of STOP
//   dbg_state[3:0]  current FSM state
// Command handshake: newd acts as a valid that is only accepted while the
// master is idle (busy=0 and done=0); a strobe seen while busy or during the
// done cycle is dropped, never queued.
// -----------------------------------------------------------------------------
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int BOARD_FREQ = DEF_BOARD_FREQ,
    parameter int I2C_FREQ   = DEF_I2C_FREQ,
    parameter int BIT_DUR    = BOARD_FREQ / I2C_FREQ,
    parameter int DELTA      = BIT_DUR / 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    input  logic       sda_in,
    output logic       sclk,
    output logic       master_sda_en,
    output logic       msda_buffer,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done,
    output logic [3:0] dbg_state
);

    i2c_state_t r_state, w_next;
    logic [3:0] r_bit;
    logic       r_op;
    logic [6:0] r_addr;
    logic [7:0] r_din;
    logic [7:0] r_dout;
    logic       r_ack_err;
    logic       r_sda;

    logic       w_busy, w_sclk, w_en, w_done;
    logic [1:0] w_phase;
    logic       w_drive, w_sample, w_bit_end;
    logic       w_last_bit;
    logic [7:0] w_addr_byte;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_last_bit  = (r_bit == 4'd7);
    assign w_addr_byte = {r_addr, r_op};

    i2c_phase_gen #(
        .BIT_DUR (BIT_DUR),
        .DELTA   (DELTA)
    ) u_phase_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (w_busy),
        .phase       (w_phase),
        .drive_tick  (w_drive),
        .sample_tick (w_sample),
        .bit_end     (w_bit_end)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus-level outputs
    always_comb begin
        w_next = r_state;
        w_sclk = 1'b1;
        w_en   = 1'b1;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (newd) w_next = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_next = ST_WRITE_ADDR;
            end
            ST_WRITE_ADDR: begin
                w_sclk = w_phase[1];
                if (w_bit_end && w_last_bit) w_next = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                w_sclk = w_phase[1];
                w_en   = 1'b0;
                // r_ack_err already reflects this slot's sample by bit end
                if (w_bit_end) begin
                    if (r_ack_err)  w_next = ST_STOP;
                    else if (r_op)  w_next = ST_READ_DATA;
                    else            w_next = ST_WRITE_DATA;
                end
            end
            ST_WRITE_DATA: begin
                w_sclk = w_phase[1];
                if (w_bit_end && w_last_bit) w_next = ST_DATA_ACK;
            end
            ST_DATA_ACK: begin
                w_sclk = w_phase[1];
                w_en   = 1'b0;
                if (w_bit_end) w_next = ST_STOP;
            end
            ST_READ_DATA: begin
                w_sclk = w_phase[1];
                w_en   = 1'b0;
                if (w_bit_end && w_last_bit) w_next = ST_MASTER_NACK;
            end
            ST_MASTER_NACK: begin
                w_sclk = w_phase[1];
                if (w_bit_end) w_next = ST_STOP;
            end
            ST_STOP: begin
                w_sclk = (w_phase != 2'd0);
                if (w_bit_end) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Command capture, bit counter, SDA drive and sampling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit     <= 4'd0;
            r_op      <= 1'b0;
            r_addr    <= 7'd0;
            r_din     <= 8'd0;
            r_dout    <= 8'd0;
            r_ack_err <= 1'b0;
            r_sda     <= 1'b1;
        end else begin
            if (r_state == ST_IDLE && newd) begin
                r_op      <= op;
                r_addr    <= addr;
                r_din     <= din;
                r_ack_err <= 1'b0;
                r_sda     <= 1'b1;
                r_bit     <= 4'd0;
            end

            // Single-bit states always exit at bit end, so r_bit stays 0 there
            if (w_bit_end) begin
                r_bit <= (w_next != r_state) ? 4'd0 : r_bit + 4'd1;
            end

            case (r_state)
                ST_START: begin
                    if (w_sample) r_sda <= 1'b0;            // START: SDA falls with SCL high
                end
                ST_WRITE_ADDR: begin
                    if (w_drive) r_sda <= w_addr_byte[~r_bit[2:0]];   // MSB first
                end
                ST_WRITE_DATA: begin
                    if (w_drive) r_sda <= r_din[~r_bit[2:0]];
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (w_sample && sda_in) r_ack_err <= 1'b1;
                end
                ST_READ_DATA: begin
                    if (w_sample) r_dout <= {r_dout[6:0], sda_in};
                end
                ST_MASTER_NACK: begin
                    if (w_drive) r_sda <= 1'b1;
                end
                ST_STOP: begin
                    if (w_sample) r_sda <= 1'b1;            // STOP: SDA rises with SCL high
                end
                default: begin
                end
            endcase

            // STOP begins with SDA low so the later rise is the STOP edge
            if (w_bit_end && w_next == ST_STOP) begin
                r_sda <= 1'b0;
            end
        end
    end

    assign sclk          = w_sclk;
    assign master_sda_en = w_en;
    assign msda_buffer   = r_sda;
    assign dout          = r_dout;
    assign busy          = w_busy;
    assign ack_err       = r_ack_err;
    assign done          = w_done;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_i2c_master_core.sv
module tb_i2c_master_core;

  localparam int BIT_CLKS = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       newd, op, sda_line;
  logic [6:0] addr;
  logic [7:0] din, dout;
  logic       sclk, master_sda_en, msda_buffer, busy, ack_err, done;
  logic [3:0] dbg_state;

  // Open-drain resolve with pull-up: master side and slave side
  logic sl_drv = 1'b0;
  logic sl_val = 1'b1;
  assign sda_line = (master_sda_en ? msda_buffer : 1'b1) & (sl_drv ? sl_val : 1'b1);

  i2c_master_core dut (
    .clk           (clk),
    .rst           (rst),
    .newd          (newd),
    .op            (op),
    .addr          (addr),
    .din           (din),
    .sda_in        (sda_line),
    .sclk          (sclk),
    .master_sda_en (master_sda_en),
    .msda_buffer   (msda_buffer),
    .dout          (dout),
    .busy          (busy),
    .ack_err       (ack_err),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem[128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus-level slave model + protocol monitor ----------------
  localparam int SL_IDLE = 0, SL_ADDR = 1, SL_AACK = 2, SL_WR = 3,
                 SL_DACK = 4, SL_RD = 5, SL_MNACK = 6;
  logic       sl_on = 1'b1;
  int         sl_st = SL_IDLE;
  int         sl_n = 0;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_rd = 8'h00;
  logic [6:0] sl_addr = 7'h00;
  logic       sl_rw = 1'b0;
  logic [7:0] sl_wdata = 8'h00;
  logic       sl_nack = 1'b0;
  logic [7:0] sl_mem[128];
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         n_start = 0;
  int         n_stop = 0;

  always @(negedge clk) begin
    logic scl, sda;
    scl = sclk;
    sda = sda_line;
    // Any SDA change with SCL high on both samples is a START or STOP edge
    if (scl && p_scl && (sda != p_sda)) begin
      if (!sda) n_start++;
      else      n_stop++;
    end
    if (!rst || !sl_on) begin
      sl_st  = SL_IDLE;
      sl_drv = 1'b0;
    end else if (scl && p_scl && p_sda && !sda) begin
      sl_st = SL_ADDR; sl_n = 0; sl_sh = 8'h00; sl_drv = 1'b0;
    end else if (scl && p_scl && !p_sda && sda) begin
      sl_st = SL_IDLE; sl_drv = 1'b0;
    end else if (!p_scl && scl) begin
      case (sl_st)
        SL_ADDR: begin
          sl_sh = {sl_sh[6:0], sda};
          sl_n++;
          if (sl_n == 8) begin
            sl_addr = sl_sh[7:1];
            sl_rw   = sl_sh[0];
            sl_st   = SL_AACK;
          end
        end
        SL_WR: begin
          sl_sh = {sl_sh[6:0], sda};
          sl_n++;
          if (sl_n == 8) begin
            sl_wdata         = sl_sh;
            sl_mem[sl_addr]  = sl_sh;
            sl_st            = SL_DACK;
          end
        end
        SL_RD:    sl_n++;
        SL_MNACK: begin sl_nack = sda; sl_st = SL_IDLE; end
        default: ;
      endcase
    end else if (p_scl && !scl) begin
      case (sl_st)
        SL_AACK: begin
          if (!sl_drv) begin
            sl_drv = 1'b1; sl_val = 1'b0;
          end else if (sl_rw) begin
            sl_st = SL_RD; sl_n = 0; sl_rd = sl_mem[sl_addr]; sl_val = sl_rd[7];
          end else begin
            sl_drv = 1'b0; sl_st = SL_WR; sl_n = 0; sl_sh = 8'h00;
          end
        end
        SL_DACK: begin
          if (!sl_drv) begin sl_drv = 1'b1; sl_val = 1'b0; end
          else begin sl_drv = 1'b0; sl_st = SL_IDLE; end
        end
        SL_RD: begin
          if (sl_n == 8) begin sl_drv = 1'b0; sl_st = SL_MNACK; end
          else sl_val = sl_rd[7 - sl_n];
        end
        default: ;
      endcase
    end
    p_scl = scl;
    p_sda = sda;
  end

  // ---------------- driver tasks ----------------
  // Issues one command at a negedge, then counts cycles from acceptance until
  // done (lat = 1 is the first cycle after the accepting edge).
  task automatic run_cmd(input logic o, input logic [6:0] a, input logic [7:0] d,
                         input int newd_at, input int rst_at,
                         output int lat, output int n_done);
    lat = 0;
    n_done = 0;
    @(negedge clk);
    newd = 1'b1; op = o; addr = a; din = d;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        newd = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
      end
      if (newd_at != 0 && c == newd_at) begin
        newd = 1'b1; addr = a ^ 7'h55; op = ~o;
      end else if (newd_at != 0 && c == newd_at + 1) begin
        newd = 1'b0; addr = a; op = o;
      end
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b0;
        #1;
        lat = c;
        break;
      end
      if (done) begin
        lat = c;
        n_done++;
        break;
      end
    end
  endtask

  task automatic txn(input string name, input logic o, input logic [6:0] a,
                     input logic [7:0] d, input logic conn, input int newd_at);
    int lat, nd, s0, p0, exp_lat;
    logic exp_ack;
    logic [7:0] exp_d;
    sl_on   = conn;
    sl_nack = 1'b0;
    s0 = n_start;
    p0 = n_stop;
    // Reference: 20 bits for a full transfer, 11 when the address is not acked
    exp_ack = ~conn;
    exp_lat = conn ? 20 * BIT_CLKS : 11 * BIT_CLKS;
    if (conn && !o) ref_mem[a] = d;
    if (conn && o)  exp_q.push_back(ref_mem[a]);
    run_cmd(o, a, d, newd_at, 0, lat, nd);
    check({name, "_done"}, nd, 1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_ack_err"}, {31'd0, ack_err}, {31'd0, exp_ack});
    if (conn) check({name, "_bus_addr_rw"}, {24'd0, sl_addr, sl_rw}, {24'd0, a, o});
    if (conn && !o) check({name, "_bus_wdata"}, {24'd0, sl_wdata}, {24'd0, d});
    if (conn && o) begin
      exp_d = exp_q.pop_front();
      check({name, "_dout"}, {24'd0, dout}, {24'd0, exp_d});
      check({name, "_master_nack"}, {31'd0, sl_nack}, 32'd1);
    end
    @(negedge clk);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_bus"}, {30'd0, sclk, sda_line}, 32'd3);
    check({name, "_starts"}, n_start - s0, 1);
    check({name, "_stops"}, n_stop - p0, 1);
    sl_on = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, nd, busy_seen;
    rst = 1'b0; newd = 1'b0; op = 1'b0; addr = 7'd0; din = 8'd0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'(i);
      sl_mem[i]  = 8'(i);
    end
    repeat (3) @(negedge clk);
    check("rst_sclk",    {31'd0, sclk}, 32'd1);
    check("rst_sda_en",  {31'd0, master_sda_en}, 32'd1);
    check("rst_msda",    {31'd0, msda_buffer}, 32'd1);
    check("rst_dout",    {24'd0, dout}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    txn("wr_a5_03", 1'b0, 7'h03, 8'hA5, 1'b1, 0);
    txn("rd_03",    1'b1, 7'h03, 8'h00, 1'b1, 0);
    txn("rd_05",    1'b1, 7'h05, 8'h00, 1'b1, 0);
    txn("addr_nack", 1'b0, 7'h2A, 8'h5A, 1'b0, 0);

    // Strobe 1000 clk into a write carrying another address: must be dropped
    txn("newd_busy", 1'b0, 7'h21, 8'h3C, 1'b1, 1000);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    check("newd_not_queued", busy_seen, 0);

    // Reset in the middle of a write
    run_cmd(1'b0, 7'h11, 8'hC3, 0, 3000, lat, nd);
    check("abort_no_done", nd, 0);
    check("abort_sclk",    {31'd0, sclk}, 32'd1);
    check("abort_sda_en",  {31'd0, master_sda_en}, 32'd1);
    check("abort_msda",    {31'd0, msda_buffer}, 32'd1);
    check("abort_dout",    {24'd0, dout}, 32'd0);
    check("abort_busy",    {31'd0, busy}, 32'd0);
    check("abort_done",    {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn("after_rst_wr", 1'b0, 7'h11, 8'hC3, 1'b1, 0);

    // Randomized commands against the reference memory
    for (int k = 0; k < 3; k++) begin
      logic ro, rc;
      logic [6:0] ra;
      logic [7:0] rd;
      ro = 1'($urandom_range(0, 1));
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      rc = ($urandom_range(0, 3) != 0);
      txn($sformatf("rnd%0d", k), ro, ra, rd, rc, 0);
    end
    txn("rd_back_11", 1'b1, 7'h11, 8'h00, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
